// File: rtl/z80_bus_arbiter.sv
// Z80 BUSRQ/BUSACK arbiter for two DMA channels with round-robin ties and a CPU gap between tenures.
// Optional tenure limit and o_expired pulse are compiled in with Z80_ARB_TENURE_LIMIT_EN.
module z80_bus_arbiter #(
  parameter int unsigned TENURE_MAX = 64,
  parameter int unsigned CPU_GAP    = 4
) (
  input  logic       mclk,
  input  logic       reset,
  input  logic [1:0] i_req,
  input  logic       i_busack_n,
  output logic       o_busrq_n,
  output logic [1:0] o_grant,
  output logic       o_bus_en,
  output logic       o_owner,
  output logic       o_expired
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_GRANT,
    ST_RELEASE,
    ST_GAP
  } state_t;

  localparam logic [3:0] GAP_LAST = 4'(CPU_GAP - 1);

  if (TENURE_MAX < 1 || TENURE_MAX > 255) begin : g_bad_tenure_max
    $error("TENURE_MAX must be in 1..255");
  end
  if (CPU_GAP < 1 || CPU_GAP > 15) begin : g_bad_cpu_gap
    $error("CPU_GAP must be in 1..15");
  end

  state_t     state, state_nxt;
  logic       busrq_n_nxt;
  logic [1:0] grant_nxt;
  logic       bus_en_nxt;
  logic       owner_nxt;
  logic [3:0] gap_cnt, gap_cnt_nxt;
  logic       winner;
  logic       limit_hit;

  // On a tie the channel that did not own the bus last time wins.
  assign winner = (i_req == 2'b11) ? ~o_owner : i_req[1];

`ifdef Z80_ARB_TENURE_LIMIT_EN
  localparam logic [7:0] TENURE_LAST = 8'(TENURE_MAX - 1);

  logic [7:0] tenure_cnt, tenure_cnt_nxt;
  logic       expired_nxt;

  assign limit_hit   = (tenure_cnt == TENURE_LAST);
  assign expired_nxt = (state == ST_GRANT) && i_req[o_owner] && limit_hit;

  always_comb begin
    tenure_cnt_nxt = tenure_cnt;
    if (state == ST_REQ) begin
      tenure_cnt_nxt = 8'd0;
    end else if (state == ST_GRANT && !limit_hit) begin
      tenure_cnt_nxt = tenure_cnt + 8'd1;
    end
  end

  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      tenure_cnt <= 8'd0;
      o_expired  <= 1'b0;
    end else begin
      tenure_cnt <= tenure_cnt_nxt;
      o_expired  <= expired_nxt;
    end
  end
`else
  assign limit_hit = 1'b0;
  assign o_expired = 1'b0;
`endif

  always_comb begin
    state_nxt   = state;
    busrq_n_nxt = o_busrq_n;
    grant_nxt   = o_grant;
    bus_en_nxt  = o_bus_en;
    owner_nxt   = o_owner;
    gap_cnt_nxt = gap_cnt;
    case (state)
      ST_IDLE: begin
        if (|i_req) begin
          busrq_n_nxt = 1'b0;
          state_nxt   = ST_REQ;
        end
      end
      ST_REQ: begin
        // BUSACK must be honoured even if every request vanished meanwhile.
        if (!i_busack_n) begin
          if (|i_req) begin
            state_nxt  = ST_GRANT;
            grant_nxt  = winner ? 2'b10 : 2'b01;
            bus_en_nxt = 1'b1;
            owner_nxt  = winner;
          end else begin
            state_nxt   = ST_RELEASE;
            busrq_n_nxt = 1'b1;
          end
        end
      end
      ST_GRANT: begin
        if (!i_req[o_owner] || limit_hit) begin
          state_nxt   = ST_RELEASE;
          grant_nxt   = 2'b00;
          bus_en_nxt  = 1'b0;
          busrq_n_nxt = 1'b1;
        end
      end
      ST_RELEASE: begin
        if (i_busack_n) begin
          state_nxt   = ST_GAP;
          gap_cnt_nxt = 4'd0;
        end
      end
      ST_GAP: begin
        if (gap_cnt == GAP_LAST) begin
          state_nxt = ST_IDLE;
        end else begin
          gap_cnt_nxt = gap_cnt + 4'd1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      o_busrq_n <= 1'b1;
      o_grant   <= 2'b00;
      o_bus_en  <= 1'b0;
      o_owner   <= 1'b1;
      gap_cnt   <= 4'd0;
    end else begin
      state     <= state_nxt;
      o_busrq_n <= busrq_n_nxt;
      o_grant   <= grant_nxt;
      o_bus_en  <= bus_en_nxt;
      o_owner   <= owner_nxt;
      gap_cnt   <= gap_cnt_nxt;
    end
  end

endmodule
